// File: rtl/soc_bus_top.sv
// Self-contained SoC bus: a BIST bus master, an address decoder, a word RAM
// slave with one wait state and a small register slave. After reset the master
// fills RAM with a pattern, reads it back and checksums it, probes an unmapped
// address, then reports the checksum and a status word into the register slave.
module soc_bus_top #(
  parameter int          N_WORDS  = 256,
  parameter logic [31:0] PAT_BASE = 32'hA5A5_0000,
  parameter logic [31:0] BAD_ADDR = 32'h2000_0000
) (
  input logic clk,
  input logic rst
);
  localparam int          AW        = $clog2(N_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * N_WORDS);
  localparam logic [31:0] REG_BASE  = 32'h1000_0000;
  localparam logic [31:0] DEAD_WORD = 32'hDEAD_BEEF;
  localparam logic [AW-1:0] LAST_IDX = AW'(N_WORDS - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, PROBE, REP_SUM, REP_STAT, DONE} state_t;

  // Bus handshake: the master raises m_req with we/addr/wdata and holds them
  // stable until a cycle with m_req && s_ready; that cycle completes the
  // transfer (write commits, read data is valid) and the next request may be
  // presented from the following cycle.
  state_t        state;
  logic          m_req;
  logic          m_we;
  logic [31:0]   m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   s_rdata;
  logic          s_ready;

  logic [AW-1:0] index;
  logic [31:0]   checksum;
  logic [15:0]   mismatch;
  logic          probe_ok;
  logic          done;
  logic          bus_err;

  logic [31:0]   mem [0:N_WORDS-1];
  logic [31:0]   regs [0:2];
  logic          ram_wait;
  logic [31:0]   ram_q;

  logic          ram_sel;
  logic          reg_sel;
  logic          bad_sel;
  logic [AW-1:0] ram_word;

  function automatic logic [31:0] pat(input logic [AW-1:0] i);
    return PAT_BASE | 32'(i);
  endfunction

  function automatic logic [31:0] word_addr(input logic [AW-1:0] i);
    return 32'(i) << 2;
  endfunction

  assign ram_sel  = (m_addr < RAM_BYTES);
  assign reg_sel  = (m_addr[31:4] == REG_BASE[31:4]);
  assign bad_sel  = !ram_sel && !reg_sel;
  assign ram_word = m_addr[AW+1:2];

  // Slave response mux: RAM answers after its wait state, regs and unmapped at once
  always_comb begin
    s_ready = 1'b0;
    s_rdata = 32'h0;
    if (m_req) begin
      if (ram_sel) begin
        s_ready = ram_wait;
        s_rdata = ram_wait ? ram_q : 32'h0;
      end else if (reg_sel) begin
        s_ready = 1'b1;
        case (m_addr[3:2])
          2'd0:    s_rdata = regs[0];
          2'd1:    s_rdata = regs[1];
          2'd2:    s_rdata = regs[2];
          default: s_rdata = 32'h0;
        endcase
      end else begin
        s_ready = 1'b1;
        s_rdata = DEAD_WORD;
      end
    end
  end

  // RAM wait state: first cycle of a request captures read data, second completes
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_wait <= 1'b0;
      ram_q    <= 32'h0;
    end else if (m_req && ram_sel && !ram_wait) begin
      ram_wait <= 1'b1;
      ram_q    <= mem[ram_word];
    end else begin
      ram_wait <= 1'b0;
    end
  end

  // RAM array is not reset; a write commits only on a completing non-reset cycle
  always_ff @(posedge clk) begin
    if (!rst && m_req && ram_sel && ram_wait && m_we)
      mem[ram_word] <= m_wdata;
  end

  // Register slave, free-running cycle counter and sticky unmapped-access flag
  always_ff @(posedge clk) begin
    if (rst) begin
      regs[0] <= 32'h0;
      regs[1] <= 32'h0;
      regs[2] <= 32'h0;
      bus_err <= 1'b0;
    end else begin
      regs[1] <= regs[1] + 32'd1;
      if (m_req && reg_sel && m_we) begin
        case (m_addr[3:2])
          2'd0:    regs[0] <= m_wdata;
          2'd2:    regs[2] <= m_wdata;
          default: ;
        endcase
      end
      if (m_req && bad_sel)
        bus_err <= 1'b1;
    end
  end

  // BIST master: requests are issued back-to-back, the next one loaded on the completing cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= 32'h0;
      m_wdata  <= 32'h0;
      index    <= '0;
      checksum <= 32'h0;
      mismatch <= 16'h0;
      probe_ok <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state   <= WRITE;
          index   <= '0;
          m_req   <= 1'b1;
          m_we    <= 1'b1;
          m_addr  <= word_addr('0);
          m_wdata <= pat('0);
        end
        WRITE: if (s_ready) begin
          if (index == LAST_IDX) begin
            state   <= READ;
            index   <= '0;
            m_we    <= 1'b0;
            m_addr  <= word_addr('0);
            m_wdata <= 32'h0;
          end else begin
            index   <= index + 1'b1;
            m_addr  <= word_addr(index + 1'b1);
            m_wdata <= pat(index + 1'b1);
          end
        end
        READ: if (s_ready) begin
          checksum <= checksum + s_rdata;
          if (s_rdata != pat(index) && mismatch != 16'hFFFF)
            mismatch <= mismatch + 16'd1;
          if (index == LAST_IDX) begin
            state  <= PROBE;
            index  <= '0;
            m_addr <= BAD_ADDR;
          end else begin
            index  <= index + 1'b1;
            m_addr <= word_addr(index + 1'b1);
          end
        end
        PROBE: if (s_ready) begin
          probe_ok <= (s_rdata == DEAD_WORD);
          state    <= REP_SUM;
          m_we     <= 1'b1;
          m_addr   <= REG_BASE;
          m_wdata  <= checksum;
        end
        REP_SUM: if (s_ready) begin
          state   <= REP_STAT;
          m_addr  <= REG_BASE + 32'h8;
          m_wdata <= {(mismatch == 16'h0) && probe_ok, probe_ok, 14'b0, mismatch};
        end
        REP_STAT: if (s_ready) begin
          state   <= DONE;
          m_req   <= 1'b0;
          m_we    <= 1'b0;
          m_addr  <= 32'h0;
          m_wdata <= 32'h0;
          done    <= 1'b1;
        end
        DONE: begin
          m_req <= 1'b0;
          if (!done) done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_bus_top.sv
// Bench for soc_bus_top: expected bus transfers, checksum and status words are
// derived from the pattern rules with plain loops; a monitor compares every
// completed transfer against that expected list.
module tb_soc_bus_top;
  localparam int          N     = 256;
  localparam logic [31:0] PAT   = 32'hA5A5_0000;
  localparam logic [31:0] BAD   = 32'h2000_0000;
  localparam logic [31:0] DEAD  = 32'hDEAD_BEEF;
  localparam logic [31:0] RBASE = 32'h1000_0000;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  soc_bus_top dut (
    .clk(clk),
    .rst(rst)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  // expected transfers: {we, addr, wdata-or-rdata}
  logic [64:0] exp_q[$];
  logic [31:0] exp_sum;
  logic [31:0] exp_status;
  logic [31:0] exp_mm;

  typedef struct {
    int          sel;   // 0: RAM word, 1: register, 2: flag
    int          idx;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Reference model: expected transfer list and results from the pattern rules
  task automatic build_model(input int bad_word);
    logic [31:0] d;
    logic [31:0] sum;
    int          mm;
    exp_q.delete();
    sum = 32'h0;
    mm  = 0;
    for (int i = 0; i < N; i++) exp_q.push_back({1'b1, 32'(4 * i), PAT + 32'(i)});
    for (int i = 0; i < N; i++) begin
      d = (i == bad_word) ? 32'h0 : PAT + 32'(i);
      sum = sum + d;
      if (d != PAT + 32'(i)) mm++;
      exp_q.push_back({1'b0, 32'(4 * i), d});
    end
    exp_q.push_back({1'b0, BAD, DEAD});
    exp_q.push_back({1'b1, RBASE, sum});
    exp_status = {(mm == 0), 1'b1, 14'b0, 16'(mm)};
    exp_q.push_back({1'b1, RBASE + 32'h8, exp_status});
    exp_sum = sum;
    exp_mm  = 32'(mm);
  endtask

  // scoreboard: every completed transfer must match the head of the expected list
  always @(negedge clk) begin
    logic [64:0] got;
    if (mon_en && !rst && dut.m_req && dut.s_ready) begin
      got = {dut.m_we, dut.m_addr, dut.m_we ? dut.m_wdata : dut.s_rdata};
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL xfer_extra: got %h expected none", got);
      end else begin
        check("xfer", got, exp_q.pop_front());
      end
    end
  end

  function automatic logic [31:0] probe_val(input int sel, input int idx);
    case (sel)
      0:       return dut.mem[idx];
      1:       return dut.regs[idx];
      default: return (idx == 0) ? 32'(dut.probe_ok) : 32'(dut.bus_err);
    endcase
  endfunction

  task automatic wait_for(input string name, input logic [31:0] addr, input logic we,
                          input int budget, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      tick();
      n++;
      if (dut.m_req && dut.m_addr == addr && dut.m_we == we) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL %s: request not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic start_run(input int bad_word);
    mon_en = 1'b0;
    rst = 1'b1;
    tick();
    build_model(bad_word);
    rst = 1'b0;
    cyc = 0;
    mon_en = 1'b1;
  endtask

  task automatic finish_run(input string name);
    int n = 0;
    while (n < 1100 && !dut.done) begin
      tick();
      n++;
    end
    check({name, "_done"}, dut.done, 1'b1);
    check({name, "_checksum"}, dut.checksum, exp_sum);
    check({name, "_mismatch"}, dut.mismatch, exp_mm);
    check({name, "_reg0"}, dut.regs[0], exp_sum);
    check({name, "_reg2"}, dut.regs[2], exp_status);
    check({name, "_cycles"}, dut.regs[1], cyc);
    check({name, "_queue_left"}, exp_q.size(), 0);
    tick();
    check({name, "_req_idle"}, dut.m_req, 1'b0);
  endtask

  initial begin
    bit ok;
    int k;

    // reset held five cycles
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_req", dut.m_req, 1'b0);
      check("rst_done", dut.done, 1'b0);
      check("rst_bus_err", dut.bus_err, 1'b0);
      check("rst_counter", dut.regs[1], 32'h0);
    end
    build_model(-1);
    rst = 1'b0;
    cyc = 0;
    mon_en = 1'b1;

    // RAM write of word 5: two request cycles, ready only on the second
    wait_for("ram_w5", 32'd20, 1'b1, 100, ok);
    if (ok) begin
      check("w5_ready_first", dut.s_ready, 1'b0);
      tick();
      check("w5_req_second", {dut.m_req, dut.m_addr}, {1'b1, 32'd20});
      check("w5_ready_second", dut.s_ready, 1'b1);
      tick();
      check("w5_ram", dut.mem[5], 32'hA5A5_0005);
    end

    // unmapped probe: ready and DEAD_BEEF same cycle, sticky error afterwards
    wait_for("probe", BAD, 1'b0, 1100, ok);
    if (ok) begin
      check("probe_ready", dut.s_ready, 1'b1);
      check("probe_rdata", dut.s_rdata, DEAD);
      check("probe_err_before", dut.bus_err, 1'b0);
      tick();
      check("probe_err_after", dut.bus_err, 1'b1);
    end
    finish_run("run1");
    check("run1_sum_const", dut.regs[0], 32'hA500_7F80);
    check("run1_stat_const", dut.regs[2], 32'hC000_0000);

    // table of post-run observations
    for (int i = 0; i < 8; i++) begin
      k = $urandom_range(0, N - 1);
      vecs[i] = '{0, k, PAT + 32'(k)};
    end
    vecs[8]  = '{1, 0, exp_sum};
    vecs[9]  = '{1, 2, exp_status};
    vecs[10] = '{2, 0, 32'h1};
    vecs[11] = '{2, 1, 32'h1};
    for (int i = 0; i < 12; i++)
      check($sformatf("vec%0d_sel%0d_idx%0d", i, vecs[i].sel, vecs[i].idx),
            probe_val(vecs[i].sel, vecs[i].idx), vecs[i].exp);

    // one-cycle reset at a random point of the read pass
    start_run(-1);
    k = $urandom_range(10, 240);
    wait_for("mid_read", 32'(4 * k), 1'b0, 1100, ok);
    mon_en = 1'b0;
    rst = 1'b1;
    tick();
    check("mid_rst_checksum", dut.checksum, 32'h0);
    check("mid_rst_mismatch", dut.mismatch, 32'h0);
    check("mid_rst_req", dut.m_req, 1'b0);
    check("mid_rst_bus_err", dut.bus_err, 1'b0);
    build_model(-1);
    rst = 1'b0;
    cyc = 0;
    mon_en = 1'b1;
    tick();
    check("restart_first_req", {dut.m_req, dut.m_we, dut.m_addr, dut.m_wdata},
          {1'b1, 1'b1, 32'h0, PAT});
    finish_run("run2");

    // corrupt word 7 after the write pass
    start_run(7);
    wait_for("read_start", 32'h0, 1'b0, 1100, ok);
    if (ok) dut.mem[7] <= 32'h0;
    finish_run("run3");
    check("run3_mismatch_const", dut.mismatch, 32'h1);
    check("run3_stat_const", dut.regs[2], 32'h4000_0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
